// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch queue entry payload.
// The adel field is only stored when FETCH_QUEUE_ADEL_EN is defined.
package cpu_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LAST   = 32'h0000_6FFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            adel;
  } fetch_entry_t;

  // Misaligned or outside the instruction memory window.
  function automatic logic pc_adel(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read, no reset.
module fetch_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order {PC, instruction} fetch queue with show-ahead head and flush on redirect.
// Optional FETCH_QUEUE_ADEL_EN adds a per-entry fetch address error flag (out_adel).
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
`ifdef FETCH_QUEUE_ADEL_EN
  output logic             out_adel,
`endif
  output logic [PTR_W:0]   count
);

`ifdef FETCH_QUEUE_ADEL_EN
  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);
`else
  localparam int unsigned ENTRY_W = 2 * XLEN;
`endif

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rp;
  logic [PTR_W:0]     cnt;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // Status depends only on registered occupancy; no full-queue pass-through.
  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt;

  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FETCH_QUEUE_ADEL_EN
  fetch_entry_t wentry;
  fetch_entry_t rentry;

  always_comb begin
    wentry       = '0;
    wentry.pc    = in_pc;
    wentry.instr = in_instr;
    wentry.adel  = pc_adel(in_pc);
  end

  assign wdata     = wentry;
  assign rentry    = fetch_entry_t'(rdata);
  assign out_pc    = out_valid ? rentry.pc    : '0;
  assign out_instr = out_valid ? rentry.instr : '0;
  assign out_adel  = out_valid & rentry.adel;
`else
  assign wdata     = {in_pc, in_instr};
  assign out_pc    = out_valid ? rdata[ENTRY_W-1 -: XLEN] : '0;
  assign out_instr = out_valid ? rdata[XLEN-1:0]          : '0;
`endif

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .Clk   (Clk),
    .we    (push & ~Reset),
    .waddr (wp),
    .wdata (wdata),
    .raddr (rp),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); covers FETCH_QUEUE_ADEL_EN when defined.
module tb_fetch_queue;

  logic        Clk;
  logic        Reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_ADEL_EN
  logic        out_adel;
`endif

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
`ifdef FETCH_QUEUE_ADEL_EN
    .out_adel  (out_adel),
`endif
    .count     (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h2400_0000 | {16'h0, pc[15:0]};
  endfunction

  task automatic set_push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  initial begin
    Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    step(); step();
    Reset = 1'b0;
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // Two pushes, decode stalled
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h2401_0001;
    step();
    check("lat_count", 32'(count), 32'd1);
    check("lat_out_pc", out_pc, 32'h3000);
    in_pc = 32'h3004; in_instr = 32'h2402_0002;
    step();
    in_valid = 1'b0;
    check("two_count", 32'(count), 32'd2);
    check("two_out_pc", out_pc, 32'h3000);
    check("two_out_instr", out_instr, 32'h2401_0001);
    check("two_in_ready", 32'(in_ready), 32'd1);

    // Fill to DEPTH, then an ignored fifth push
    set_push(32'h3008); step();
    set_push(32'h300C); step();
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    set_push(32'h3010); step();
    check("full_ignore_count", 32'(count), 32'd4);
    check("full_ignore_head", out_pc, 32'h3000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    check("full_pop_head", out_pc, 32'h3004);
    check("full_pop_instr", out_instr, 32'h2402_0002);

    // Flush to empty, then pop attempt on empty queue
    flush = 1'b1; step(); flush = 1'b0;
    check("flush1_count", 32'(count), 32'd0);
    out_ready = 1'b1; step();
    check("empty_pop_count", 32'(count), 32'd0);
    check("empty_pop_valid", 32'(out_valid), 32'd0);

    // Steady stream, wraps pointers past entry 3
    for (int k = 0; k < 10; k++) begin
      set_push(32'h3000 + 32'(4 * k));
      step();
      check($sformatf("stream_count_%0d", k), 32'(count), 32'd1);
      check($sformatf("stream_pc_%0d", k), out_pc, 32'h3000 + 32'(4 * k));
      check($sformatf("stream_instr_%0d", k), out_instr, instr_of(32'h3000 + 32'(4 * k)));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);

    // Flush with concurrent push drops everything
    set_push(32'h3100); step();
    set_push(32'h3104); step();
    set_push(32'h3108); step();
    check("pre_flush_count", 32'(count), 32'd3);
    check("pre_flush_head", out_pc, 32'h3100);
    flush = 1'b1; set_push(32'h3400);
    step();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_pc", out_pc, 32'h0);
    check("flush_out_instr", out_instr, 32'h0);
    step();
    check("post_flush_count", 32'(count), 32'd1);
    check("post_flush_head", out_pc, 32'h3400);
    check("post_flush_instr", out_instr, instr_of(32'h3400));

    // Reset mid-operation with a push pending
    set_push(32'h3404); step();
    set_push(32'h3408); step();
    check("pre_rst_count", 32'(count), 32'd3);
    Reset = 1'b1; set_push(32'h340C);
    step();
    Reset = 1'b0; in_valid = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_pc", out_pc, 32'h0);

`ifdef FETCH_QUEUE_ADEL_EN
    set_push(32'h3002); step();
    set_push(32'h7000); step();
    set_push(32'h3008); step();
    in_valid = 1'b0;
    check("adel_0", 32'(out_adel), 32'd1);
    out_ready = 1'b1; step();
    check("adel_1", 32'(out_adel), 32'd1);
    check("adel_1_pc", out_pc, 32'h7000);
    step();
    check("adel_2", 32'(out_adel), 32'd0);
    check("adel_2_pc", out_pc, 32'h3008);
    step();
    out_ready = 1'b0;
    check("adel_empty", 32'(out_adel), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
